// File: rtl/ib_transformer_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ib_transformer_arbiter_pkg
// Purpose : shared types and constants for the two-port packet arbiter that
//           feeds the transformer.
// Contents: arb_state_t (FSM state), PORT0/PORT1 (port index constants used
//           for the round-robin "last served" pointer).
// ---------------------------------------------------------------------------
package ib_transformer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/ib_arb_sat_cnt.sv
// ---------------------------------------------------------------------------
// ib_arb_sat_cnt
// Purpose : saturating packet counter with synchronous clear.
// Ports   : i_clk    - clock, rising edge
//           i_rst    - asynchronous active-high reset (value -> 0)
//           i_inc    - add one this cycle (ignored once all ones)
//           i_clr    - synchronous clear, wins over i_inc
//           o_value  - current count
// ---------------------------------------------------------------------------
module ib_arb_sat_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_inc,
  input  logic                 i_clr,
  output logic [CNT_WIDTH-1:0] o_value
);

  logic [CNT_WIDTH-1:0] r_value;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_value <= '0;
    end else if (i_clr) begin
      r_value <= '0;
    end else if (i_inc && (r_value != {CNT_WIDTH{1'b1}})) begin
      r_value <= r_value + CNT_WIDTH'(1);
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/ib_transformer_arbiter.sv
// ---------------------------------------------------------------------------
// ib_transformer_arbiter
// Purpose : packet-locked round-robin arbiter merging two requester streams
//           into one transformer stream. Pure 2:1 mux, no buffering.
// Ports   : i_clk, i_reset            - clock / async active-high reset
//           i_in{0,1}_data/_sop_n/_eop_n/_src_rdy_n - requester words
//           o_in{0,1}_dst_rdy_n       - accept toward each requester
//           o_out_data/_sop_n/_eop_n/_src_rdy_n     - merged stream
//           i_out_dst_rdy_n           - transformer ready
//           i_cnt_clr                 - synchronous clear of both counters
//           o_pkt_cnt0/1              - packets forwarded per port (saturating)
// ---------------------------------------------------------------------------
module ib_transformer_arbiter
  import ib_transformer_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_in0_data,
  input  logic                  i_in0_sop_n,
  input  logic                  i_in0_eop_n,
  input  logic                  i_in0_src_rdy_n,
  output logic                  o_in0_dst_rdy_n,
  input  logic [DATA_WIDTH-1:0] i_in1_data,
  input  logic                  i_in1_sop_n,
  input  logic                  i_in1_eop_n,
  input  logic                  i_in1_src_rdy_n,
  output logic                  o_in1_dst_rdy_n,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_sop_n,
  output logic                  o_out_eop_n,
  output logic                  o_out_src_rdy_n,
  input  logic                  i_out_dst_rdy_n,
  input  logic                  i_cnt_clr,
  output logic [CNT_WIDTH-1:0]  o_pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  o_pkt_cnt1
);

  arb_state_t r_state;
  logic       r_rr;      // port served most recently; the other one wins a tie

  logic w_req0, w_req1;
  logic w_eop0, w_eop1;

  // Only a valid SOP word opens a request; mid-packet words never do.
  assign w_req0 = ~i_in0_src_rdy_n & ~i_in0_sop_n;
  assign w_req1 = ~i_in1_src_rdy_n & ~i_in1_sop_n;

  // EOP transfer of the granted port: the only event that releases a grant.
  assign w_eop0 = (r_state == ST_GRANT0) & ~i_in0_src_rdy_n & ~i_out_dst_rdy_n & ~i_in0_eop_n;
  assign w_eop1 = (r_state == ST_GRANT1) & ~i_in1_src_rdy_n & ~i_out_dst_rdy_n & ~i_in1_eop_n;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_rr    <= PORT1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req0 && w_req1) begin
            r_state <= (r_rr == PORT1) ? ST_GRANT0 : ST_GRANT1;
          end else if (w_req0) begin
            r_state <= ST_GRANT0;
          end else if (w_req1) begin
            r_state <= ST_GRANT1;
          end
        end
        ST_GRANT0: begin
          if (w_eop0) begin
            r_rr    <= PORT0;
            // Hand straight over to a waiting port 1 so no idle cycle is lost.
            r_state <= w_req1 ? ST_GRANT1 : ST_IDLE;
          end
        end
        ST_GRANT1: begin
          if (w_eop1) begin
            r_rr    <= PORT1;
            r_state <= w_req0 ? ST_GRANT0 : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: combinational 2:1 mux selected by the registered grant.
  always_comb begin
    o_out_data      = '0;
    o_out_sop_n     = 1'b1;
    o_out_eop_n     = 1'b1;
    o_out_src_rdy_n = 1'b1;
    o_in0_dst_rdy_n = 1'b1;
    o_in1_dst_rdy_n = 1'b1;
    case (r_state)
      ST_GRANT0: begin
        o_out_data      = i_in0_data;
        o_out_sop_n     = i_in0_sop_n;
        o_out_eop_n     = i_in0_eop_n;
        o_out_src_rdy_n = i_in0_src_rdy_n;
        o_in0_dst_rdy_n = i_out_dst_rdy_n;
      end
      ST_GRANT1: begin
        o_out_data      = i_in1_data;
        o_out_sop_n     = i_in1_sop_n;
        o_out_eop_n     = i_in1_eop_n;
        o_out_src_rdy_n = i_in1_src_rdy_n;
        o_in1_dst_rdy_n = i_out_dst_rdy_n;
      end
      default: ;
    endcase
  end

  ib_arb_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt0 (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_inc   (w_eop0),
    .i_clr   (i_cnt_clr),
    .o_value (o_pkt_cnt0)
  );

  ib_arb_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt1 (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_inc   (w_eop1),
    .i_clr   (i_cnt_clr),
    .o_value (o_pkt_cnt1)
  );

endmodule

// File: tb/tb_ib_transformer_arbiter.sv
module tb_ib_transformer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in0_data, in1_data;
  logic        in0_sop_n, in0_eop_n, in0_src_rdy_n;
  logic        in1_sop_n, in1_eop_n, in1_src_rdy_n;
  logic        out_dst_rdy_n, cnt_clr;

  logic        in0_dst_rdy_n, in1_dst_rdy_n;
  logic [63:0] out_data;
  logic        out_sop_n, out_eop_n, out_src_rdy_n;
  logic [15:0] pkt_cnt0, pkt_cnt1;

  logic        c4_in0_dst_rdy_n, c4_in1_dst_rdy_n;
  logic [63:0] c4_out_data;
  logic        c4_out_sop_n, c4_out_eop_n, c4_out_src_rdy_n;
  logic [3:0]  c4_cnt0, c4_cnt1;

  typedef struct packed {
    logic [63:0] d;
    logic        sop_n;
    logic        eop_n;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;
  int   sop_cyc[2];
  int   eop_cyc[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ib_transformer_arbiter #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_in0_data(in0_data), .i_in0_sop_n(in0_sop_n), .i_in0_eop_n(in0_eop_n),
    .i_in0_src_rdy_n(in0_src_rdy_n), .o_in0_dst_rdy_n(in0_dst_rdy_n),
    .i_in1_data(in1_data), .i_in1_sop_n(in1_sop_n), .i_in1_eop_n(in1_eop_n),
    .i_in1_src_rdy_n(in1_src_rdy_n), .o_in1_dst_rdy_n(in1_dst_rdy_n),
    .o_out_data(out_data), .o_out_sop_n(out_sop_n), .o_out_eop_n(out_eop_n),
    .o_out_src_rdy_n(out_src_rdy_n), .i_out_dst_rdy_n(out_dst_rdy_n),
    .i_cnt_clr(cnt_clr), .o_pkt_cnt0(pkt_cnt0), .o_pkt_cnt1(pkt_cnt1)
  );

  // Narrow-counter copy on the same traffic, used for saturation checks.
  ib_transformer_arbiter #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut_c4 (
    .i_clk(clk), .i_reset(rst),
    .i_in0_data(in0_data), .i_in0_sop_n(in0_sop_n), .i_in0_eop_n(in0_eop_n),
    .i_in0_src_rdy_n(in0_src_rdy_n), .o_in0_dst_rdy_n(c4_in0_dst_rdy_n),
    .i_in1_data(in1_data), .i_in1_sop_n(in1_sop_n), .i_in1_eop_n(in1_eop_n),
    .i_in1_src_rdy_n(in1_src_rdy_n), .o_in1_dst_rdy_n(c4_in1_dst_rdy_n),
    .o_out_data(c4_out_data), .o_out_sop_n(c4_out_sop_n), .o_out_eop_n(c4_out_eop_n),
    .o_out_src_rdy_n(c4_out_src_rdy_n), .i_out_dst_rdy_n(out_dst_rdy_n),
    .i_cnt_clr(cnt_clr), .o_pkt_cnt0(c4_cnt0), .o_pkt_cnt1(c4_cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int port, input int id, input int idx);
    return {16'hC0DE, 8'(port), 8'(id), 16'(idx), 16'(id * 7 + idx)};
  endfunction

  task automatic push_pkt(input int port, input int id, input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.d     = mk(port, id, i);
      e.sop_n = (i == 0) ? 1'b0 : 1'b1;
      e.eop_n = (i == len - 1) ? 1'b0 : 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic set_word(input int port, input logic [63:0] d,
                          input logic sop_n, input logic eop_n, input logic src_n);
    if (port == 0) begin
      in0_data = d; in0_sop_n = sop_n; in0_eop_n = eop_n; in0_src_rdy_n = src_n;
    end else begin
      in1_data = d; in1_sop_n = sop_n; in1_eop_n = eop_n; in1_src_rdy_n = src_n;
    end
  endtask

  task automatic send_pkt(input int port, input int id, input int len);
    for (int i = 0; i < len; i++) begin
      int t;
      t = 0;
      set_word(port, mk(port, id, i), (i == 0) ? 1'b0 : 1'b1,
               (i == len - 1) ? 1'b0 : 1'b1, 1'b0);
      while (1) begin
        @(negedge clk);
        if (((port == 0) ? in0_dst_rdy_n : in1_dst_rdy_n) == 1'b0) break;
        t++;
        if (t > 300) begin
          vecs++;
          errs++;
          $error("FAIL accept_timeout: port %0d pkt %0d word %0d got no accept, required accept within 300 cycles",
                 port, id, i);
          set_word(port, 64'h0, 1'b1, 1'b1, 1'b1);
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    set_word(port, 64'h0, 1'b1, 1'b1, 1'b1);
  endtask

  // Output monitor: a transfer commits at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_src_rdy_n == 1'b0 && out_dst_rdy_n == 1'b0) begin
      int   p;
      exp_t e;
      p = int'(out_data[47:40]);
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_sop_n", 64'(out_sop_n), 64'(e.sop_n));
        chk("out_eop_n", 64'(out_eop_n), 64'(e.eop_n));
      end
      if (p < 2) begin
        if (!out_sop_n) sop_cyc[p] = cyc;
        if (!out_eop_n) eop_cyc[p] = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion before 30000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_word(0, 64'h0, 1'b1, 1'b1, 1'b1);
    set_word(1, 64'h0, 1'b1, 1'b1, 1'b1);
    out_dst_rdy_n = 1'b0;
    cnt_clr       = 1'b0;
    sop_cyc[0] = 0; sop_cyc[1] = 0; eop_cyc[0] = 0; eop_cyc[1] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_src_rdy_n", 64'(out_src_rdy_n), 64'd1);
    chk("rst_out_sop_n", 64'(out_sop_n), 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in0_dst_rdy_n", 64'(in0_dst_rdy_n), 64'd1);
    chk("rst_in1_dst_rdy_n", 64'(in1_dst_rdy_n), 64'd1);
    chk("rst_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("rst_cnt1", 64'(pkt_cnt1), 64'd0);
    rst = 1'b0;

    // Tie right after reset: port 0 first, port 1 follows with no bubble.
    @(posedge clk); #1;
    push_pkt(0, 1, 2);
    push_pkt(1, 1, 3);
    fork
      send_pkt(0, 1, 2);
      send_pkt(1, 1, 3);
    join
    @(negedge clk);
    chk("tie_sb_drained", 64'(sb.size()), 64'd0);
    chk("tie_no_bubble", 64'(sop_cyc[1]), 64'(eop_cyc[0] + 1));
    chk("tie_cnt0", 64'(pkt_cnt0), 64'd1);
    chk("tie_cnt1", 64'(pkt_cnt1), 64'd1);

    // Back-pressure on word 2 of a 4-word port 0 packet; port 1 waiting.
    @(posedge clk); #1;
    push_pkt(0, 2, 4);
    push_pkt(1, 2, 2);
    fork
      send_pkt(0, 2, 4);
      send_pkt(1, 2, 2);
      begin
        for (int k = 0; k < 100; k++) begin
          @(posedge clk); #2;
          if (out_src_rdy_n == 1'b0 && out_data == mk(0, 2, 1)) break;
        end
        out_dst_rdy_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_in0_dst_rdy_n", 64'(in0_dst_rdy_n), 64'd1);
          chk("stall_in1_dst_rdy_n", 64'(in1_dst_rdy_n), 64'd1);
          chk("stall_out_data", out_data, mk(0, 2, 1));
          @(posedge clk);
        end
        #2;
        out_dst_rdy_n = 1'b0;
        #1;
        chk("stall_release_in0_dst_rdy_n", 64'(in0_dst_rdy_n), 64'd0);
      end
    join
    @(negedge clk);
    chk("stall_sb_drained", 64'(sb.size()), 64'd0);
    chk("stall_cnt0", 64'(pkt_cnt0), 64'd2);
    chk("stall_cnt1", 64'(pkt_cnt1), 64'd2);

    // Valid word without SOP on port 1 in IDLE is not a request.
    @(posedge clk); #1;
    set_word(1, 64'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("nosop_in1_dst_rdy_n", 64'(in1_dst_rdy_n), 64'd1);
      chk("nosop_out_src_rdy_n", 64'(out_src_rdy_n), 64'd1);
    end
    @(posedge clk); #1;
    set_word(1, 64'h0, 1'b1, 1'b1, 1'b1);

    // Saturation: 17 single-word packets on port 0.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("clr_c4_cnt0", 64'(c4_cnt0), 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 17; k++) begin
      push_pkt(0, 10 + k, 1);
      send_pkt(0, 10 + k, 1);
    end
    @(negedge clk);
    chk("sat_cnt0_w16", 64'(pkt_cnt0), 64'd17);
    chk("sat_cnt0_w4", 64'(c4_cnt0), 64'd15);

    // Clear coincident with an EOP transfer: clear wins.
    @(posedge clk); #1;
    push_pkt(0, 40, 1);
    fork
      send_pkt(0, 40, 1);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (in0_dst_rdy_n == 1'b0 && in0_src_rdy_n == 1'b0) break;
        end
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
      end
    join
    @(negedge clk);
    chk("clr_eop_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("clr_eop_c4_cnt0", 64'(c4_cnt0), 64'd0);
    chk("clr_eop_sb_drained", 64'(sb.size()), 64'd0);

    // Reset on word 2 of a port 1 packet aborts it.
    @(posedge clk); #1;
    push_pkt(1, 50, 1);  // only the SOP word is expected to leave
    sb[sb.size() - 1].eop_n = 1'b1;
    set_word(1, mk(1, 50, 0), 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in1_dst_rdy_n == 1'b0) break;
    end
    @(posedge clk); #1;
    set_word(1, mk(1, 50, 1), 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_src_rdy_n", 64'(out_src_rdy_n), 64'd1);
    chk("abort_in1_dst_rdy_n", 64'(in1_dst_rdy_n), 64'd1);
    chk("abort_cnt1", 64'(pkt_cnt1), 64'd0);
    chk("abort_cnt0", 64'(pkt_cnt0), 64'd0);
    set_word(1, 64'h0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sb_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
    push_pkt(0, 60, 2);
    push_pkt(1, 60, 1);
    fork
      send_pkt(0, 60, 2);
      send_pkt(1, 60, 1);
    join
    @(negedge clk);
    chk("abort_tie_sb_drained", 64'(sb.size()), 64'd0);
    chk("abort_tie_port0_first", 64'(sop_cyc[0] < sop_cyc[1]), 64'd1);

    // 100 packets with both ports continuously requesting.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int k = 0; k < 50; k++) begin
      push_pkt(0, k, (k % 3) + 1);
      push_pkt(1, k, ((k + 1) % 3) + 1);
    end
    fork
      begin
        for (int k = 0; k < 50; k++) send_pkt(0, k, (k % 3) + 1);
      end
      begin
        for (int k = 0; k < 50; k++) send_pkt(1, k, ((k + 1) % 3) + 1);
      end
    join
    @(negedge clk);
    chk("rr_sb_drained", 64'(sb.size()), 64'd0);
    chk("rr_cnt0", 64'(pkt_cnt0), 64'd50);
    chk("rr_cnt1", 64'(pkt_cnt1), 64'd50);
    chk("rr_c4_cnt0", 64'(c4_cnt0), 64'd15);
    chk("rr_c4_cnt1", 64'(c4_cnt1), 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ib_transformer_arbiter.md
IB_TRANSFORMER_ARBITER -- requirements
Module: ib_transformer_arbiter

Interface
REQ-001 Generic DATA_WIDTH, default 64, data width of both input ports and the output port.
REQ-002 Generic CNT_WIDTH, default 16, width of each per-port packet counter.
REQ-003 CLK  in  1  single clock; all logic on rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 IN0_DATA / IN1_DATA  in  DATA_WIDTH  requester data words.
REQ-006 IN0_SOP_N / IN1_SOP_N  in  1  start of packet, active low.
REQ-007 IN0_EOP_N / IN1_EOP_N  in  1  end of packet, active low.
REQ-008 IN0_SRC_RDY_N / IN1_SRC_RDY_N  in  1  requester word valid, active low.
REQ-009 IN0_DST_RDY_N / IN1_DST_RDY_N  out  1  arbiter accepts word, active low.
REQ-010 OUT_DATA  out  DATA_WIDTH  word toward the transformer.
REQ-011 OUT_SOP_N, OUT_EOP_N, OUT_SRC_RDY_N  out  1 each  forwarded framing and valid, active low.
REQ-012 OUT_DST_RDY_N  in  1  transformer ready, active low.
REQ-013 CNT_CLR  in  1  synchronous clear of both packet counters.
REQ-014 PKT_CNT0 / PKT_CNT1  out  CNT_WIDTH  packets forwarded per port.

Function
REQ-015 A transfer on a port occurs in a cycle where its SRC_RDY_N=0 and DST_RDY_N=0.
REQ-016 FSM states: IDLE, GRANT0, GRANT1; state, RR pointer and counters are registered.
REQ-017 Port x requests when INx_SRC_RDY_N=0 and INx_SOP_N=0; a valid word without SOP is never a request.
REQ-018 IDLE: one request -> grant that port next cycle; both -> grant the port not served last (RR pointer); none -> stay IDLE.
REQ-019 Grant latency: exactly one cycle from first request in IDLE to GRANTx.
REQ-020 In GRANTx: OUT_DATA/SOP_N/EOP_N/SRC_RDY_N = INx values combinationally; INx_DST_RDY_N = OUT_DST_RDY_N.
REQ-021 Outside GRANTx: INx_DST_RDY_N=1; in IDLE, OUT_SRC_RDY_N=1, OUT_SOP_N=1, OUT_EOP_N=1, OUT_DATA=0.
REQ-022 Grant is locked until the EOP word of port x transfers; SOP-only stalls or OUT_DST_RDY_N=1 never release it.
REQ-023 On EOP transfer in GRANTx: if other port requests -> GRANT(other) next cycle, no bubble; else -> IDLE.
REQ-024 RR pointer updates to x on every EOP transfer from port x.
REQ-025 Single-word packet (SOP_N=0, EOP_N=0 same word) completes and releases the grant in one transfer.
REQ-026 PKT_CNTx increments by 1 on each EOP transfer from port x; saturates at all ones.
REQ-027 CNT_CLR=1 zeroes both counters that cycle; clear has priority over a simultaneous increment.

Reset
REQ-028 RESET=1 forces IDLE, RR pointer=1 (port 0 wins first tie), PKT_CNT0=PKT_CNT1=0, all DST_RDY_N=1, OUT_SRC_RDY_N=1.
REQ-029 Reset asserted mid-packet aborts the packet; no partial state persists after RESET deasserts.

Structure
REQ-030 FSM state type and port-index constants live in shared package ib_transformer_arbiter_pkg.
REQ-031 Each counter is an instance of sub-module ib_arb_sat_cnt (CNT_WIDTH, inc, clr, value).
REQ-032 No buffering inside the block; datapath is a 2:1 mux.

Verification
REQ-033 Both ports request in the cycle after reset -> port 0 granted first; after its EOP, port 1 granted next cycle with no bubble.
REQ-034 Port 0 sends 4-word packet with OUT_DST_RDY_N high on word 2 for 3 cycles -> port 1 never granted mid-packet; IN0_DST_RDY_N mirrors stall.
REQ-035 Port 1 asserts SRC_RDY_N=0 with SOP_N=1 in IDLE -> no grant, IN1_DST_RDY_N stays 1.
REQ-036 CNT_WIDTH=4, 17 single-word packets on port 0 -> PKT_CNT0=15; CNT_CLR with concurrent EOP -> 0.
REQ-037 RESET asserted on word 2 of a port 1 packet -> IDLE, counters 0, port 0 wins next tie.
REQ-038 Alternating continuous requests on both ports for 100 packets -> strict 0,1,0,1 grant order, counters 50/50.
